// File: rtl/bus_arbit_pkg.sv
// Shared definitions for the N-master bus arbiter: policy encoding,
// hold counter width and the grant index width helper.
package bus_arbit_pkg;

    // Arbitration policy selector
    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,   // lowest index wins
        ARB_RR    = 1'b1    // round-robin, scanning from owner+1
    } arb_mode_t;

    // Hold counter is wide enough for the largest legal MAX_HOLD (255)
    localparam int HOLD_W = 8;

    // Width of a binary master index; never less than one bit
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational rotating-priority picker: scans req starting at base,
// wrapping at N-1 -> 0, skipping masters set in excl.
module arb_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    input  logic [N-1:0]  excl,
    output logic [IW-1:0] win,
    output logic          vld
);

    logic [N-1:0] cand;

    // Walk the ring from the far end back to base so the closest hit wins
    always_comb begin
        logic [IW-1:0] ix;
        cand = req & ~excl;
        win  = '0;
        vld  = 1'b0;
        ix   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            ix = IW'((int'(base) + k) % N);
            if (cand[ix]) begin
                win = ix;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbit_n.sv
// N-master bus arbiter. The owner lives in a register and the grant
// outputs are pure decodes of it, so the bus is always granted to exactly
// one master (parking on master 0 when idle). Optional MAX_HOLD forces the
// owner to yield after MAX_HOLD consecutive grant cycles if anyone else wants
// the bus.
module bus_arbit_n
    import bus_arbit_pkg::*;
#(
    parameter int        NUM_M    = 2,
    parameter arb_mode_t MODE     = ARB_FIXED,
    parameter int        MAX_HOLD = 0,
    localparam int       IDW      = idw(NUM_M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_M-1:0] m_req,
    output logic [NUM_M-1:0] m_grant,
    output logic [IDW-1:0]   grant_id,
    output logic             grant_chg
);

    logic [IDW-1:0]    owner, owner_nxt, base, win;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [NUM_M-1:0]  req_s, own_oh;
    logic              win_vld, own_req, others_req, preempt, chg_nxt;

    // Anything that is not a clean 1 counts as no request
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NUM_M; i++)
            req_s[i] = (m_req[i] === 1'b1);
    end

    assign own_oh     = NUM_M'(1) << owner;
    assign own_req    = |(req_s & own_oh);
    assign others_req = |(req_s & ~own_oh);

    // hold_cnt is 0 in the first grant cycle, so the cycle count so far is
    // hold_cnt+1; yield at the edge that closes the MAX_HOLD-th cycle.
    assign preempt = (MAX_HOLD != 0) && (int'(hold_cnt) + 1 >= MAX_HOLD) && others_req;

    // Round-robin scans from the master after the owner; fixed always from 0
    always_comb begin
        base = '0;
        if (MODE == ARB_RR)
            base = (owner == IDW'(NUM_M - 1)) ? '0 : owner + 1'b1;
    end

    // Owner is excluded: either it dropped its request or it is being preempted
    arb_pick #(.N(NUM_M), .IW(IDW)) u_pick (
        .req  (req_s),
        .base (base),
        .excl (own_oh),
        .win  (win),
        .vld  (win_vld)
    );

    // Next owner, counter update and change flag
    always_comb begin
        owner_nxt = owner;
        if (!own_req || preempt)
            owner_nxt = win_vld ? win : '0;
        chg_nxt  = (owner_nxt != owner);
        hold_nxt = hold_cnt;
        if (chg_nxt)
            hold_nxt = '0;
        else if ((MAX_HOLD != 0) && (int'(hold_cnt) < MAX_HOLD))
            hold_nxt = hold_cnt + 1'b1;
    end

    // Owner register
    always_ff @(posedge clk) begin
        if (reset) owner <= '0;
        else       owner <= owner_nxt;
    end

    // Consecutive-ownership counter, saturating
    always_ff @(posedge clk) begin
        if (reset) hold_cnt <= '0;
        else       hold_cnt <= hold_nxt;
    end

    // One-cycle pulse after an ownership change
    always_ff @(posedge clk) begin
        if (reset) grant_chg <= 1'b0;
        else       grant_chg <= chg_nxt;
    end

    assign m_grant  = own_oh;
    assign grant_id = owner;

endmodule

// File: tb/tb_bus_arbit_n.sv
// Bench for bus_arbit_n: four configurations run side by side from one
// clock and reset. Expected grants come from hand tables and from an
// independent cycle model, queued at drive time and compared after the edge.
module tb_bus_arbit_n;
    import bus_arbit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // cfg0: 2 FIXED 0   cfg1: 4 RR 0   cfg2: 4 FIXED 3   cfg3: 5 RR 2
    logic [1:0] req_a = '0, g_a;  logic [0:0] id_a;  logic chg_a;
    logic [3:0] req_b = '0, g_b;  logic [1:0] id_b;  logic chg_b;
    logic [3:0] req_c = '0, g_c;  logic [1:0] id_c;  logic chg_c;
    logic [4:0] req_d = '0, g_d;  logic [2:0] id_d;  logic chg_d;

    bus_arbit_n #(.NUM_M(2), .MODE(ARB_FIXED), .MAX_HOLD(0)) dut_a (
        .clk(clk), .reset(reset), .m_req(req_a), .m_grant(g_a), .grant_id(id_a), .grant_chg(chg_a));
    bus_arbit_n #(.NUM_M(4), .MODE(ARB_RR), .MAX_HOLD(0)) dut_b (
        .clk(clk), .reset(reset), .m_req(req_b), .m_grant(g_b), .grant_id(id_b), .grant_chg(chg_b));
    bus_arbit_n #(.NUM_M(4), .MODE(ARB_FIXED), .MAX_HOLD(3)) dut_c (
        .clk(clk), .reset(reset), .m_req(req_c), .m_grant(g_c), .grant_id(id_c), .grant_chg(chg_c));
    bus_arbit_n #(.NUM_M(5), .MODE(ARB_RR), .MAX_HOLD(2)) dut_d (
        .clk(clk), .reset(reset), .m_req(req_d), .m_grant(g_d), .grant_id(id_d), .grant_chg(chg_d));

    typedef struct {
        int         cfg;
        logic [7:0] g;
        int         id;
        bit         chg;
        string      nm;
    } exp_t;

    typedef struct {
        logic [7:0] req;
        logic [7:0] g;
        int         id;
        bit         chg;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model configuration and state: owner and cycles held including current
    int nm_c[4] = '{2, 4, 4, 5};
    int md_c[4] = '{0, 1, 0, 1};   // 1 = round-robin
    int mh_c[4] = '{0, 0, 3, 2};
    int m_own[4]  = '{0, 0, 0, 0};
    int m_held[4] = '{1, 1, 1, 1};

    function automatic logic [7:0] act_g(input int c);
        case (c)
            0: return {6'b0, g_a};
            1: return {4'b0, g_b};
            2: return {4'b0, g_c};
            default: return {3'b0, g_d};
        endcase
    endfunction

    function automatic int act_id(input int c);
        case (c)
            0: return int'(id_a);
            1: return int'(id_b);
            2: return int'(id_c);
            default: return int'(id_d);
        endcase
    endfunction

    function automatic bit act_chg(input int c);
        case (c)
            0: return chg_a;
            1: return chg_b;
            2: return chg_c;
            default: return chg_d;
        endcase
    endfunction

    task automatic push_exp(input int c, input logic [7:0] g, input int id, input bit chg, input string nm);
        exp_t e;
        e.cfg = c; e.g = g; e.id = id; e.chg = chg; e.nm = nm;
        sb_q.push_back(e);
    endtask

    // Advance the reference model one edge and queue what it predicts
    task automatic model_push(input int c, input bit rst, input logic [7:0] req, input string nm);
        logic [7:0] r, others, cand;
        int  nown, own, idx;
        bit  chg, frc, found;
        own = m_own[c];
        r   = req & ((8'(1) << nm_c[c]) - 8'(1));
        if (rst) begin
            nown = 0; chg = 1'b0; m_held[c] = 1;
        end else begin
            others = r & ~(8'(1) << own);
            frc = (mh_c[c] != 0) && (m_held[c] >= mh_c[c]) && (others != 0);
            nown = own;
            if (!r[own] || frc) begin
                cand = frc ? others : r;
                nown = 0; found = 1'b0;
                for (int k = 0; k < nm_c[c]; k++) begin
                    idx = (md_c[c] == 1) ? (own + 1 + k) % nm_c[c] : k;
                    if (!found && cand[idx]) begin
                        nown = idx; found = 1'b1;
                    end
                end
            end
            chg = (nown != own);
            if (chg) m_held[c] = 1;
            else if (m_held[c] < mh_c[c]) m_held[c] = m_held[c] + 1;
        end
        m_own[c] = nown;
        push_exp(c, 8'(1) << nown, nown, chg, nm);
    endtask

    // Drive one cycle, let it clock, then drain the scoreboard
    task automatic cycle(input bit rst, input logic [7:0] ra, input logic [7:0] rb,
                         input logic [7:0] rc, input logic [7:0] rd, input string nm);
        exp_t e;
        reset = rst;
        req_a = ra[1:0]; req_b = rb[3:0]; req_c = rc[3:0]; req_d = rd[4:0];
        model_push(0, rst, ra, nm);
        model_push(1, rst, rb, nm);
        model_push(2, rst, rc, nm);
        model_push(3, rst, rd, nm);
        @(posedge clk);
        #1;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if (act_g(e.cfg) !== e.g || act_id(e.cfg) != e.id || act_chg(e.cfg) !== e.chg) begin
                errors++;
                $display("FAIL %s cfg%0d got g=%b id=%0d chg=%0d want g=%b id=%0d chg=%0d",
                         e.nm, e.cfg, act_g(e.cfg), act_id(e.cfg), act_chg(e.cfg), e.g, e.id, e.chg);
            end
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (!$onehot(act_g(c)) || act_g(c) != (8'(1) << act_id(c))) begin
                errors++;
                $display("FAIL onehot cfg%0d got g=%b id=%0d", c, act_g(c), act_id(c));
            end
        end
    endtask

    vec_t tbl[8];

    initial begin
        // Two-master fixed arbiter behaviour
        tbl[0] = '{req: 8'b00, g: 8'b01, id: 0, chg: 1'b0};
        tbl[1] = '{req: 8'b10, g: 8'b10, id: 1, chg: 1'b1};
        tbl[2] = '{req: 8'b11, g: 8'b10, id: 1, chg: 1'b0};
        tbl[3] = '{req: 8'b11, g: 8'b10, id: 1, chg: 1'b0};
        tbl[4] = '{req: 8'b01, g: 8'b01, id: 0, chg: 1'b1};
        tbl[5] = '{req: 8'b11, g: 8'b01, id: 0, chg: 1'b0};
        tbl[6] = '{req: 8'b10, g: 8'b10, id: 1, chg: 1'b1};
        tbl[7] = '{req: 8'b00, g: 8'b01, id: 0, chg: 1'b1};

        // Reset state on every configuration
        for (int c = 0; c < 4; c++) push_exp(c, 8'b1, 0, 1'b0, "reset");
        cycle(1'b1, 0, 0, 0, 0, "reset");
        cycle(1'b1, 8'hff, 8'hff, 8'hff, 8'hff, "reset_req");

        foreach (tbl[i]) begin
            push_exp(0, tbl[i].g, tbl[i].id, tbl[i].chg, "fixed2_tbl");
            cycle(1'b0, tbl[i].req, 0, 0, 0, "fixed2");
        end

        // Round-robin hand-off order
        push_exp(1, 8'b0010, 1, 1'b1, "rr_own1");    cycle(1'b0, 0, 8'b0010, 0, 0, "rr");
        push_exp(1, 8'b0100, 2, 1'b1, "rr_to2");     cycle(1'b0, 0, 8'b1101, 0, 0, "rr");
        push_exp(1, 8'b1000, 3, 1'b1, "rr_to3");     cycle(1'b0, 0, 8'b1001, 0, 0, "rr");
        push_exp(1, 8'b0001, 0, 1'b1, "rr_to0");     cycle(1'b0, 0, 8'b0001, 0, 0, "rr");
        push_exp(1, 8'b0001, 0, 1'b0, "rr_hold0");   cycle(1'b0, 0, 8'b1111, 0, 0, "rr");
        push_exp(1, 8'b0010, 1, 1'b1, "rr_wrap1");   cycle(1'b0, 0, 8'b1110, 0, 0, "rr");

        // Forced yield after three grant cycles
        push_exp(2, 8'b0100, 2, 1'b1, "hold_g0");    cycle(1'b0, 0, 0, 8'b0100, 0, "hold");
        push_exp(2, 8'b0100, 2, 1'b0, "hold_g1");    cycle(1'b0, 0, 0, 8'b0110, 0, "hold");
        push_exp(2, 8'b0100, 2, 1'b0, "hold_g2");    cycle(1'b0, 0, 0, 8'b0110, 0, "hold");
        push_exp(2, 8'b0010, 1, 1'b1, "hold_yield"); cycle(1'b0, 0, 0, 8'b0110, 0, "hold");
        push_exp(2, 8'b0010, 1, 1'b0, "hold_m1a");   cycle(1'b0, 0, 0, 8'b0110, 0, "hold");
        push_exp(2, 8'b0010, 1, 1'b0, "hold_m1b");   cycle(1'b0, 0, 0, 8'b0110, 0, "hold");
        push_exp(2, 8'b0100, 2, 1'b1, "hold_back");  cycle(1'b0, 0, 0, 8'b0110, 0, "hold");

        // Lone requester keeps the bus past MAX_HOLD; one change pulse only
        cycle(1'b1, 0, 0, 0, 0, "rst2");
        for (int i = 0; i < 10; i++) begin
            push_exp(2, 8'b1000, 3, (i == 0), "sat");
            cycle(1'b0, 0, 0, 8'b1000, 0, "sat");
        end

        // Reset mid-ownership revokes without a pulse
        push_exp(2, 8'b0001, 0, 1'b0, "rst_revoke"); cycle(1'b1, 0, 0, 8'b1000, 0, "rstmid");
        push_exp(2, 8'b1000, 3, 1'b1, "rst_regrant"); cycle(1'b0, 0, 0, 8'b1000, 0, "rstmid");

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  8'($urandom & $urandom), 8'($urandom & $urandom),
                  8'($urandom & $urandom), 8'($urandom & $urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbit_n.md
BUS_ARBIT_N -- requirements
Module: bus_arbit_n

Interface
REQ-001 Parameter NUM_M, default 2, meaning number of masters (legal 2..8).
REQ-002 Parameter MODE, default ARB_FIXED, meaning arbitration policy (ARB_FIXED = lowest index wins; ARB_RR = round-robin).
REQ-003 Parameter MAX_HOLD, default 0, meaning max consecutive grant cycles before forced yield (0 = unlimited; legal 0..255).
REQ-004 Port list, clock and reset first: clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 m_req  input  NUM_M  per-master bus request, bit i = master i.
REQ-007 m_grant  output  NUM_M  one-hot grant, bit i = master i owns bus.
REQ-008 grant_id  output  IDW = max(1,$clog2(NUM_M))  binary index of current owner.
REQ-009 grant_chg  output  1  one-cycle pulse, owner changed on this edge.

Function
REQ-010 Owner SHALL be held in a register; m_grant and grant_id SHALL be decoded from it only, so exactly one m_grant bit is high in every cycle, including idle (bus parks).
REQ-011 Owner update: 1 clk cycle after the deciding m_req sample; no combinational req->grant path.
REQ-012 Owner keeps bus while its m_req=1 and no preemption (REQ-014) applies.
REQ-013 Owner drops m_req: next owner = winner among requesting masters per MODE; none requesting -> park on master 0.
REQ-014 MAX_HOLD>0: hold counter counts cycles of current ownership; when count = MAX_HOLD and any other master requests, owner SHALL yield to the MODE winner among the other requesters, even if its m_req=1.
REQ-015 MAX_HOLD>0, count = MAX_HOLD, no other requester: owner keeps bus; counter saturates at MAX_HOLD.
REQ-016 Hold counter SHALL clear to 0 on every owner change (including re-park on 0) and never wrap.
REQ-017 ARB_FIXED winner: lowest-index requesting master.
REQ-018 ARB_RR winner: first requesting master scanning owner+1, owner+2, ... wrapping NUM_M-1 -> 0; current owner considered last.
REQ-019 Simultaneous owner drop and new requests in same cycle: decision uses that cycle's m_req only.
REQ-020 grant_chg=1 exactly in the cycle after an edge where owner changed; 0 otherwise, including reset cycles.
REQ-021 NUM_M=2, MODE=ARB_FIXED, MAX_HOLD=0: cycle-identical to the existing two-master arbiter (master 0 parked; M0->M1 only when m_req=2'b10; M1->M0 when m_req[1]=0).
REQ-022 X/undefined m_req bits SHALL be treated as 0 (no X propagation into owner).

Reset
REQ-023 reset=1 at a rising edge: owner=0, m_grant=1 (bit 0), grant_id=0, grant_chg=0, hold counter=0.
REQ-024 Reset mid-ownership SHALL revoke grant immediately at that edge with no grant_chg pulse; first arbitration occurs at first edge with reset=0.
REQ-025 No asynchronous reset path.

Structure
REQ-026 Package bus_arbit_pkg SHALL hold ARB_FIXED/ARB_RR constants, arb_mode_t typedef and IDW helper function.
REQ-027 Sub-module arb_pick: combinational rotating-priority picker (req vector, base index, exclude mask -> winner index + valid); both modes SHALL use it (FIXED base=0).
REQ-028 Owner register, hold counter and grant_chg flop in bus_arbit_n; single always block per register group.

Verification
REQ-029 NUM_M=2 FIXED: reset, m_req=00 -> grant 01; m_req=10 -> next cycle grant 10, grant_chg=1; m_req=11 -> grant 10 held; m_req=01 -> grant 01.
REQ-030 NUM_M=4 RR: owner 1, m_req=1101 then owner drops bit... m_req=1101 -> owner 2? no: owner1 drops, requesters {0,2,3} -> grant 0100 (id 2); then 2 drops -> id 3; then 3 drops -> id 0.
REQ-031 NUM_M=4 FIXED, MAX_HOLD=3: master 2 holds, m_req=0110 from start -> grant moves to id 1 exactly 3 cycles after master 2 granted; counter clears.
REQ-032 MAX_HOLD=3, only master 3 requesting for 10 cycles -> grant stays id 3, grant_chg pulses once.
REQ-033 Owner id 3 with m_req=1000, assert reset one cycle -> grant 0001, grant_chg=0; release reset -> grant 1000 one cycle later.
REQ-034 Random m_req 10k cycles, all configs: assert m_grant one-hot every cycle and grant_id matches.
